demux_pry_reg: RTL and testbench
================================

DEMUX_PRY_REG -- requirements
Module: demux_pry_reg

Interface
REQ-001 The block SHALL have parameter DAT_T, default logic [8-1:0], the payload data type.
REQ-002 The block SHALL have parameter WIDTH, default 4, the number of output lanes; legal values are 2 or more.
REQ-003 The block SHALL have parameter CNT_W, default 16, the width of the drop counter.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-006 The block SHALL have port i_vld, input, 1 bit, the input transfer valid.
REQ-007 The block SHALL have port i_rdy, output, 1 bit, the input transfer ready.
REQ-008 The block SHALL have port i_pry, input, WIDTH bits, the destination priority mask; the lowest set bit wins.
REQ-009 The block SHALL have port i_dat, input, DAT_T, the input payload.
REQ-010 The block SHALL have port o_vld, output, WIDTH bits, the per-lane valid; it is one-hot or zero.
REQ-011 The block SHALL have port o_rdy, input, WIDTH bits, the per-lane ready.
REQ-012 The block SHALL have port o_idx, output, $clog2(WIDTH) bits, the binary index of the lane currently selected.
REQ-013 The block SHALL have port o_dat, output, DAT_T, the payload shared by all lanes.
REQ-014 The block SHALL have port drp_cnt, output, CNT_W bits, the count of dropped transfers.

Function
REQ-015 An input handshake SHALL occur in a cycle where i_vld and i_rdy are both 1.
REQ-016 An output handshake SHALL occur in a cycle where o_vld[k] and o_rdy[k] are both 1; o_rdy of non-selected lanes SHALL be ignored.
REQ-017 At input handshake the block SHALL compute the lane as the lowest set bit of i_pry and store it, in one-hot form and in binary form, together with i_dat.
REQ-018 An input handshake with i_pry == 0 SHALL be accepted and discarded: no state change, and drp_cnt increments, saturating at 2**CNT_W-1.
REQ-019 The block SHALL contain a two-entry buffer (main and skid) with state EMPTY, ONE or TWO; o_vld, o_idx and o_dat SHALL be driven only from the main register.
REQ-020 i_rdy SHALL be 1 exactly when the state is not TWO, decoded from registered state only, with no combinational path from o_rdy.
REQ-021 From EMPTY, a valid input SHALL load main and move to ONE; o_vld asserts the next cycle, giving 1-cycle latency.
REQ-022 From ONE with both handshakes in the same cycle, main SHALL be reloaded from the input and the state SHALL stay ONE, giving full throughput.
REQ-023 From ONE with only the output handshake, the state SHALL move to EMPTY.
REQ-024 From ONE with only the input handshake, the input SHALL load skid and the state SHALL move to TWO.
REQ-025 From TWO, an output handshake SHALL copy skid to main and move to ONE; no input is accepted in TWO.
REQ-026 In the EMPTY state, o_vld SHALL be all zero.
REQ-027 While o_vld is asserted, o_vld, o_idx and o_dat SHALL stay stable until the output handshake.
REQ-028 Transfers SHALL leave the block in input-handshake order; no reordering between lanes.
REQ-029 A zero-mask input arriving in the same cycle as an output handshake SHALL have both events applied independently.

Reset
REQ-030 While rst_n is 0, the state SHALL be EMPTY, o_vld 0, o_idx 0, o_dat 0, drp_cnt 0 and i_rdy 1.
REQ-031 Assertion of rst_n in mid-operation SHALL discard buffered entries immediately, with no output handshake completing.
REQ-032 After rst_n deasserts, the first input handshake SHALL be possible in the first clock edge following.

Verification
REQ-033 Single transfer: i_pry=4'b0110, i_dat=8'hA5, o_rdy=4'b1111 -> one cycle later o_vld=4'b0010, o_idx=1, o_dat=8'hA5, then o_vld=0.
REQ-034 Backpressure: o_rdy=0, three inputs 8'h01, 8'h02, 8'h03 offered -> the first two are accepted, i_rdy=0, and the third is held. With o_rdy=1 the outputs are 01, 02, 03 in order with no loss.
REQ-035 Streaming: i_vld=1 and o_rdy=all ones for 10 cycles -> 10 outputs with one per cycle, i_rdy constantly 1.
REQ-036 Drop: i_pry=0 for 3 transfers -> drp_cnt=3, o_vld stays 0. With CNT_W=2, 5 drops -> drp_cnt=3 (saturated).
REQ-037 Wrong-lane ready: o_vld=4'b1000 with o_rdy=4'b0111 -> no handshake, outputs stable. With o_rdy[3]=1 -> handshake.
REQ-038 Reset mid-operation: state TWO, rst_n pulsed low between clock edges -> o_vld=0 and i_rdy=1 immediately, and the buffered data never appears.

Source files
------------

// File: rtl/demux_pry_reg.sv
// Priority-mask demultiplexer with a two-entry (main + skid) output buffer.
// The lowest set bit of i_pry selects the lane; an all-zero mask is dropped and counted.
module demux_pry_reg #(
    parameter type DAT_T = logic [8-1:0],
    parameter int  WIDTH = 4,
    parameter int  CNT_W = 16,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vld,
    output logic             i_rdy,
    input  logic [WIDTH-1:0] i_pry,
    input  DAT_T             i_dat,
    output logic [WIDTH-1:0] o_vld,
    input  logic [WIDTH-1:0] o_rdy,
    output logic [IDX_W-1:0] o_idx,
    output DAT_T             o_dat,
    output logic [CNT_W-1:0] drp_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] f_lsb_oh(input logic [WIDTH-1:0] pry);
        return pry & (~pry + WIDTH'(1));
    endfunction

    // One-hot input is guaranteed, so OR-ing the indices of set bits is exact.
    function automatic logic [IDX_W-1:0] f_oh2idx(input logic [WIDTH-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = idx | (oh[i] ? IDX_W'(i) : IDX_W'(0));
        end
        return idx;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_main_oh;
    logic [IDX_W-1:0]  r_main_idx;
    DAT_T              r_main_dat;
    logic [WIDTH-1:0]  r_skid_oh;
    logic [IDX_W-1:0]  r_skid_idx;
    DAT_T              r_skid_dat;
    logic [CNT_W-1:0]  r_drp_cnt;

    logic              w_i_rdy;
    logic              w_in_hs;
    logic              w_ld;
    logic              w_drop;
    logic              w_out_hs;
    logic [WIDTH-1:0]  w_in_oh;
    logic [IDX_W-1:0]  w_in_idx;
    logic              w_ld_main_in;
    logic              w_ld_main_skid;
    logic              w_ld_skid;
    logic              w_clr_main;

    // Main one-hot is kept zero when empty, so it doubles as the lane valid.
    assign w_i_rdy  = (r_state != ST_TWO);
    assign w_in_hs  = i_vld & w_i_rdy;
    assign w_ld     = w_in_hs & (|i_pry);
    assign w_drop   = w_in_hs & ~(|i_pry);
    assign w_out_hs = |(r_main_oh & o_rdy);
    assign w_in_oh  = f_lsb_oh(i_pry);
    assign w_in_idx = f_oh2idx(w_in_oh);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode from load and output handshakes.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_ld) w_state_nxt = ST_ONE;
                else      w_state_nxt = ST_EMPTY;
            end
            ST_ONE: begin
                if (w_ld && !w_out_hs)      w_state_nxt = ST_TWO;
                else if (!w_ld && w_out_hs) w_state_nxt = ST_EMPTY;
                else                        w_state_nxt = ST_ONE;
            end
            ST_TWO: begin
                if (w_out_hs) w_state_nxt = ST_ONE;
                else          w_state_nxt = ST_TWO;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Buffer-move controls per state.
    always_comb begin
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        w_clr_main     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_ld_main_in = w_ld;
            end
            ST_ONE: begin
                w_ld_main_in = w_ld & w_out_hs;
                w_ld_skid    = w_ld & ~w_out_hs;
                w_clr_main   = ~w_ld & w_out_hs;
            end
            ST_TWO: begin
                w_ld_main_skid = w_out_hs;
            end
            default: begin
                w_clr_main = 1'b1;
            end
        endcase
    end

    // Main/skid datapath and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_oh  <= '0;
            r_main_idx <= '0;
            r_main_dat <= '0;
            r_skid_oh  <= '0;
            r_skid_idx <= '0;
            r_skid_dat <= '0;
            r_drp_cnt  <= '0;
        end else begin
            if (w_ld_main_in) begin
                r_main_oh  <= w_in_oh;
                r_main_idx <= w_in_idx;
                r_main_dat <= i_dat;
            end else if (w_ld_main_skid) begin
                r_main_oh  <= r_skid_oh;
                r_main_idx <= r_skid_idx;
                r_main_dat <= r_skid_dat;
            end else if (w_clr_main) begin
                r_main_oh  <= '0;
            end
            if (w_ld_skid) begin
                r_skid_oh  <= w_in_oh;
                r_skid_idx <= w_in_idx;
                r_skid_dat <= i_dat;
            end
            if (w_drop && (r_drp_cnt != {CNT_W{1'b1}})) begin
                r_drp_cnt <= r_drp_cnt + CNT_W'(1);
            end
        end
    end

    assign i_rdy   = w_i_rdy;
    assign o_vld   = r_main_oh;
    assign o_idx   = r_main_idx;
    assign o_dat   = r_main_dat;
    assign drp_cnt = r_drp_cnt;

endmodule

// File: tb/tb_demux_pry_reg.sv
// Randomized + directed bench for demux_pry_reg against a queue-based reference model.
module tb_demux_pry_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_vld = 1'b0;
    logic [3:0]  i_pry = 4'd0;
    logic [7:0]  i_dat = 8'd0;
    logic [3:0]  o_rdy = 4'd0;
    logic        i_rdy, i_rdy2;
    logic [3:0]  o_vld, o_vld2;
    logic [1:0]  o_idx, o_idx2;
    logic [7:0]  o_dat, o_dat2;
    logic [15:0] drp_cnt;
    logic [1:0]  drp_cnt2;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int         lane;
        logic [7:0] dat;
    } ent_t;
    ent_t q[$];
    int   m_drp  = 0;
    int   m_drp2 = 0;

    demux_pry_reg dut (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_rdy(i_rdy), .i_pry(i_pry),
        .i_dat(i_dat), .o_vld(o_vld), .o_rdy(o_rdy), .o_idx(o_idx), .o_dat(o_dat),
        .drp_cnt(drp_cnt)
    );

    demux_pry_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .i_vld(i_vld), .i_rdy(i_rdy2), .i_pry(i_pry),
        .i_dat(i_dat), .o_vld(o_vld2), .o_rdy(o_rdy), .o_idx(o_idx2), .o_dat(o_dat2),
        .drp_cnt(drp_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] p);
        for (int i = 0; i < 4; i++) begin
            if (p[i]) return i;
        end
        return -1;
    endfunction

    // Reference model: FIFO of at most two entries, drops counted with saturation.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_drp  = 0;
            m_drp2 = 0;
        end else begin
            bit acc, pop;
            acc = i_vld && (q.size() < 2);
            pop = (q.size() > 0) && o_rdy[q[0].lane];
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (i_pry == 4'd0) begin
                    if (m_drp < 65535) m_drp++;
                    if (m_drp2 < 3) m_drp2++;
                end else begin
                    q.push_back('{lane: lowest(i_pry), dat: i_dat});
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("i_rdy", 32'(i_rdy), 32'(q.size() < 2));
            chk("o_vld", 32'(o_vld), (q.size() > 0) ? (32'd1 << q[0].lane) : 32'd0);
            if (q.size() > 0) begin
                chk("o_idx", 32'(o_idx), 32'(q[0].lane));
                chk("o_dat", 32'(o_dat), 32'(q[0].dat));
            end
            chk("drp_cnt", 32'(drp_cnt), 32'(m_drp));
            chk("drp_cnt_sat", 32'(drp_cnt2), 32'(m_drp2));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        #1;
        chk("rst_i_rdy", 32'(i_rdy), 32'd1);
        chk("rst_o_vld", 32'(o_vld), 32'd0);
        chk("rst_o_idx", 32'(o_idx), 32'd0);
        chk("rst_o_dat", 32'(o_dat), 32'd0);
        chk("rst_drp", 32'(drp_cnt), 32'd0);
        #12 rst_n = 1'b1;

        // Drops: three, then two more to saturate the 2-bit counter.
        step(); i_vld = 1'b1; i_pry = 4'd0; o_rdy = 4'hF; i_dat = 8'h77;
        repeat (3) step();
        i_vld = 1'b0;
        step();
        chk("drop3", 32'(drp_cnt), 32'd3);
        chk("drop3_vld", 32'(o_vld), 32'd0);
        i_vld = 1'b1;
        repeat (2) step();
        i_vld = 1'b0;
        step();
        chk("drop5", 32'(drp_cnt), 32'd5);
        chk("drop5_sat", 32'(drp_cnt2), 32'd3);

        // Single transfer.
        i_vld = 1'b1; i_pry = 4'b0110; i_dat = 8'hA5; o_rdy = 4'hF;
        step(); i_vld = 1'b0;
        chk("single_vld", 32'(o_vld), 32'h2);
        chk("single_idx", 32'(o_idx), 32'd1);
        chk("single_dat", 32'(o_dat), 32'hA5);
        step();
        chk("single_done", 32'(o_vld), 32'd0);

        // Backpressure: third input held while two are buffered.
        o_rdy = 4'd0; i_vld = 1'b1; i_pry = 4'b0001; i_dat = 8'h01;
        step(); i_dat = 8'h02;
        step(); i_dat = 8'h03;
        chk("bp_rdy0", 32'(i_rdy), 32'd0);
        chk("bp_dat01", 32'(o_dat), 32'h01);
        step();
        chk("bp_rdy0b", 32'(i_rdy), 32'd0);
        o_rdy = 4'hF;
        step();
        chk("bp_dat02", 32'(o_dat), 32'h02);
        chk("bp_rdy1", 32'(i_rdy), 32'd1);
        step(); i_vld = 1'b0;
        chk("bp_dat03", 32'(o_dat), 32'h03);
        step();
        chk("bp_empty", 32'(o_vld), 32'd0);

        // Streaming: one output per cycle.
        cnt = 0;
        i_vld = 1'b1; i_pry = 4'b0100; i_dat = 8'd0; o_rdy = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("stream_rdy", 32'(i_rdy), 32'd1);
            chk("stream_dat", 32'(o_dat), 32'(k - 1));
            if (o_vld != 4'd0) cnt++;
            if (k < 10) i_dat = 8'(k);
            else        i_vld = 1'b0;
        end
        step();
        chk("stream_cnt", 32'(cnt), 32'd10);
        chk("stream_end", 32'(o_vld), 32'd0);

        // Wrong-lane ready is ignored.
        i_vld = 1'b1; i_pry = 4'b1000; i_dat = 8'h5A; o_rdy = 4'b0111;
        step(); i_vld = 1'b0;
        chk("wl_vld", 32'(o_vld), 32'h8);
        chk("wl_idx", 32'(o_idx), 32'd3);
        step();
        chk("wl_hold_vld", 32'(o_vld), 32'h8);
        chk("wl_hold_dat", 32'(o_dat), 32'h5A);
        o_rdy = 4'b1000;
        step();
        chk("wl_done", 32'(o_vld), 32'd0);

        // Reset mid-operation from the two-entry state.
        o_rdy = 4'd0; i_vld = 1'b1; i_pry = 4'b0010; i_dat = 8'hC1;
        step(); i_dat = 8'hC2;
        step(); i_vld = 1'b0;
        chk("pre_rst_rdy", 32'(i_rdy), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(o_vld), 32'd0);
        chk("mid_rst_rdy", 32'(i_rdy), 32'd1);
        #1 rst_n = 1'b1;
        o_rdy = 4'hF; i_vld = 1'b1; i_pry = 4'b0001; i_dat = 8'hD0;
        step(); i_vld = 1'b0;
        chk("post_rst_vld", 32'(o_vld), 32'h1);
        chk("post_rst_dat", 32'(o_dat), 32'hD0);

        // Randomized traffic checked by the model.
        for (int k = 0; k < 600; k++) begin
            step();
            i_vld = ($urandom_range(0, 3) != 0);
            i_pry = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
            i_dat = 8'($urandom);
            o_rdy = 4'($urandom);
        end
        step();
        i_vld = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
